// File: rtl/instr_cache.sv
// Direct-mapped, read-only L1 instruction cache.
// Hits are answered combinationally in the same cycle the fetch address
// is presented. Misses fill a whole 32-byte line from physical memory
// through a two-state IDLE/FETCH controller. A flush pulse invalidates
// every line at the next edge.
module instr_cache #(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  imem_address,
    output logic [31:0]  imem_rdata,
    output logic         imem_resp,
    input  logic         flush,
    output logic         pmem_read,
    output logic [31:0]  pmem_address,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int LINES = 1 << S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t state, state_next;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [255:0]     data_q [LINES];

    logic [31:0]        fill_address_q;
    logic               flush_seen_q;

    logic [S_INDEX-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [S_INDEX-1:0] fill_index;
    logic [TAG_W-1:0]   fill_tag;
    logic [7:0]         word_lsb;
    logic               tag_match;
    logic               start_fill;
    logic               fill_done;

    assign req_index  = imem_address[5 +: S_INDEX];
    assign req_tag    = imem_address[31 -: TAG_W];
    assign fill_index = fill_address_q[5 +: S_INDEX];
    assign fill_tag   = fill_address_q[31 -: TAG_W];
    assign word_lsb   = {imem_address[4:2], 5'b00000};

    assign tag_match    = valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign imem_rdata   = data_q[req_index][word_lsb +: 32];
    assign pmem_address = fill_address_q;

    // State register; an asynchronous reset drops FETCH (and pmem_read) at once.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode: hit/miss in IDLE, wait for the fill in FETCH.
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        imem_resp  = 1'b0;
        pmem_read  = 1'b0;
        start_fill = 1'b0;
        fill_done  = 1'b0;
        case (state)
            IDLE: begin
                // A flush cycle neither hits nor starts a fill.
                if (!flush) begin
                    if (tag_match) begin
                        imem_resp = 1'b1;
                    end else begin
                        start_fill = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                // Flush does not abort the bus transaction already in flight.
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Latch the line-aligned miss address and remember flushes seen during a fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_address_q <= '0;
            flush_seen_q   <= 1'b0;
        end else begin
            if (start_fill) begin
                fill_address_q <= {imem_address[31:5], 5'b00000};
                flush_seen_q   <= 1'b0;
            end else if (state == FETCH && flush) begin
                flush_seen_q   <= 1'b1;
            end
        end
    end

    // Valid bits: set by a clean fill, cleared wholesale by flush (flush wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (fill_done && !flush && !flush_seen_q) begin
                valid_q[fill_index] <= 1'b1;
            end
            if (flush) begin
                valid_q <= '0;
            end
        end
    end

    // Tag and data storage written on fill completion at the latched index.
    // NOTE: tag/data arrays carry no reset; the reset valid bits alone make
    // their power-up contents unobservable, and this keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= pmem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed fetch/fill/flush/reset
// scenarios, a line-level cache model compared on every falling edge, and
// literal expectations at the points the scenarios pin down.
module tb_instr_cache;

    localparam int S_INDEX = 3;
    localparam int LINES   = 1 << S_INDEX;
    localparam int TAG_W   = 27 - S_INDEX;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  imem_address;
    logic [31:0]  imem_rdata;
    logic         imem_resp;
    logic         flush;
    logic         pmem_read;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int errors = 0;

    instr_cache #(.S_INDEX(S_INDEX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .flush        (flush),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- cache model ----------------
    bit                m_valid [LINES];
    logic [TAG_W-1:0]  m_tag   [LINES];
    logic [255:0]      m_data  [LINES];
    bit                m_fetching;
    bit                m_flushed;
    logic [31:0]       m_line_addr;

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[5 +: S_INDEX]);
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
        return a[31 -: TAG_W];
    endfunction

    function automatic bit model_hit(input logic [31:0] a, input logic f);
        return !m_fetching && !f && m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
            m_fetching  = 1'b0;
            m_flushed   = 1'b0;
            m_line_addr = '0;
        end else begin
            if (!m_fetching) begin
                if (!flush && !model_hit(imem_address, flush)) begin
                    m_fetching  = 1'b1;
                    m_flushed   = 1'b0;
                    m_line_addr = {imem_address[31:5], 5'b00000};
                end
            end else if (pmem_resp) begin
                m_tag[idx_of(m_line_addr)]   = tag_of(m_line_addr);
                m_data[idx_of(m_line_addr)]  = pmem_rdata;
                m_valid[idx_of(m_line_addr)] = !(flush || m_flushed);
                m_fetching = 1'b0;
            end else if (flush) begin
                m_flushed = 1'b1;
            end
            if (flush) begin
                for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        bit exp_resp;
        exp_resp = model_hit(imem_address, flush) && rst_n;
        check("model_resp", {31'd0, imem_resp}, {31'd0, exp_resp});
        if (exp_resp)
            check("model_rdata", imem_rdata,
                  m_data[idx_of(imem_address)][32*int'(imem_address[4:2]) +: 32]);
        check("model_pmem_read", {31'd0, pmem_read}, {31'd0, m_fetching});
        if (m_fetching)
            check("model_pmem_address", pmem_address, m_line_addr);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present addr, wait for the fill request, answer after 'delay' cycles.
    // Optionally pulse flush at fetch cycle flush_at and switch the fetch
    // address to switch_addr once the fill has started.
    task automatic fill(input logic [31:0] addr, input int delay, input logic [255:0] line,
                        input int flush_at, input bit do_switch, input logic [31:0] switch_addr);
        int n;
        int cnt;
        imem_address = addr;
        n = 0;
        while (!pmem_read && n < 10) begin
            tick();
            n++;
        end
        check("fill_start", {31'd0, pmem_read}, 32'd1);
        if (!pmem_read) return;
        check("fill_address", pmem_address, {addr[31:5], 5'b00000});
        if (do_switch) begin
            imem_address = switch_addr;
            #1;
            check("resp_in_fetch", {31'd0, imem_resp}, 32'd0);
        end
        cnt = 0;
        for (int i = 0; i <= delay; i++) begin
            if (pmem_read) cnt++;
            flush = (i == flush_at);
            if (i == delay) begin
                pmem_resp  = 1'b1;
                pmem_rdata = line;
            end
            tick();
        end
        pmem_resp = 1'b0;
        flush     = 1'b0;
        check("read_cycles", 32'(cnt), 32'(delay + 1));
        check("read_low_after_resp", {31'd0, pmem_read}, 32'd0);
    endtask

    task automatic expect_hit(input logic [31:0] a, input logic [31:0] data);
        imem_address = a;
        #1;
        check("hit_resp", {31'd0, imem_resp}, 32'd1);
        check("hit_rdata", imem_rdata, data);
        check("hit_no_read", {31'd0, pmem_read}, 32'd0);
        tick();
    endtask

    logic [255:0] line1, line2, line3;

    initial begin
        line1 = mk_line(32'h1000_0000);
        line2 = mk_line(32'h2000_0000);
        line3 = mk_line(32'h3000_0000);
        rst_n        = 1'b0;
        imem_address = 32'h0000_0040;
        flush        = 1'b0;
        pmem_resp    = 1'b0;
        pmem_rdata   = '0;
        #1;
        check("reset_resp", {31'd0, imem_resp}, 32'd0);
        check("reset_read", {31'd0, pmem_read}, 32'd0);
        check("reset_paddr", pmem_address, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Cold miss
        #1;
        check("cold_miss_resp", {31'd0, imem_resp}, 32'd0);
        fill(32'h40, 3, line1, -1, 1'b0, 32'h0);
        #1;
        check("cold_fill_resp", {31'd0, imem_resp}, 32'd1);
        check("cold_fill_rdata", imem_rdata, 32'h1000_0000);
        tick();

        // Same-line hits
        expect_hit(32'h44, 32'h1000_0001);
        expect_hit(32'h5C, 32'h1000_0007);
        expect_hit(32'h4E, 32'h1000_0003);

        // Conflict miss
        fill(32'h140, 2, line2, -1, 1'b0, 32'h0);
        expect_hit(32'h140, 32'h2000_0000);
        imem_address = 32'h40;
        #1;
        check("conflict_remiss", {31'd0, imem_resp}, 32'd0);
        fill(32'h40, 1, line1, -1, 1'b0, 32'h0);
        expect_hit(32'h48, 32'h1000_0002);

        // Flush in IDLE
        imem_address = 32'h40;
        flush = 1'b1;
        #1;
        check("flush_idle_resp", {31'd0, imem_resp}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("after_flush_resp", {31'd0, imem_resp}, 32'd0);
        check("after_flush_no_read", {31'd0, pmem_read}, 32'd0);
        fill(32'h40, 1, line1, -1, 1'b0, 32'h0);
        expect_hit(32'h40, 32'h1000_0000);

        // Flush two cycles into a fill: line stays invalid and refetches
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fill(32'h40, 4, line1, 2, 1'b0, 32'h0);
        #1;
        check("flush_fetch_remiss", {31'd0, imem_resp}, 32'd0);
        fill(32'h40, 1, line1, -1, 1'b0, 32'h0);
        expect_hit(32'h40, 32'h1000_0000);

        // Flush coincident with pmem_resp
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fill(32'h40, 2, line1, 2, 1'b0, 32'h0);
        #1;
        check("flush_resp_remiss", {31'd0, imem_resp}, 32'd0);
        fill(32'h40, 0, line1, -1, 1'b0, 32'h0);
        expect_hit(32'h40, 32'h1000_0000);

        // Address changes mid-fetch to a resident line: no response during FETCH
        fill(32'h60, 3, line3, -1, 1'b1, 32'h40);
        expect_hit(32'h40, 32'h1000_0000);
        expect_hit(32'h68, 32'h3000_0002);

        // Reset mid-fetch
        imem_address = 32'h140;
        begin
            int n;
            n = 0;
            while (!pmem_read && n < 10) begin
                tick();
                n++;
            end
        end
        check("pre_reset_read", {31'd0, pmem_read}, 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check("async_reset_read", {31'd0, pmem_read}, 32'd0);
        check("async_reset_resp", {31'd0, imem_resp}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("post_reset_miss_140", {31'd0, imem_resp}, 32'd0);
        fill(32'h140, 1, line2, -1, 1'b0, 32'h0);
        imem_address = 32'h60;
        #1;
        check("post_reset_miss_60", {31'd0, imem_resp}, 32'd0);
        fill(32'h60, 0, line3, -1, 1'b0, 32'h0);
        expect_hit(32'h7C, 32'h3000_0007);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only L1 instruction cache between the pipeline's IF stage and physical memory. It serves the fetch port (`imem_address` → `imem_rdata`/`imem_resp`) on hits in the same cycle, and fills whole 256-bit lines from physical memory on misses. While `imem_resp` is low, the IF/ID register and PC stall. A `flush` input supports fence.i by invalidating every line.

## Interface
- `S_INDEX`, default 3: index bits; the cache holds 2**S_INDEX lines.
- Line size is fixed at 32 bytes (offset = addr[4:0]).
- Tag = addr[31:5+S_INDEX], width 27-S_INDEX.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_address` in 32: fetch address; a request is implied every cycle; bits [1:0] ignored.
- `imem_rdata` out 32: word addr[4:2] of the hit line.
- `imem_resp` out 1: high when `imem_rdata` is valid for the current `imem_address`.
- `flush` in 1: one-cycle pulse; invalidates all lines.
- `pmem_read` out 1: line-fill request.
- `pmem_address` out 32: line-aligned fill address, low 5 bits 0.
- `pmem_rdata` in 256: fill data, valid in the `pmem_resp` cycle.
- `pmem_resp` in 1: one-cycle completion pulse.

## Operation
- Storage:
  - per line: valid bit, tag register, 256-bit data register;
  - valid bits are reset; tag and data are not.
- Hit is combinational: valid[idx] && tag[idx]==addr tag && state==IDLE && !flush.
- `imem_resp` = hit. `imem_rdata` = data[idx][32*addr[4:2] +: 32]. It is don't-care when `imem_resp`=0.
- FSM:
  - IDLE: on miss (and no flush), latch {addr[31:5],5'b0} into `pmem_address` → FETCH.
  - FETCH: `pmem_read`=1 and `pmem_address` held constant. On `pmem_resp`: write data and tag at the latched index → IDLE.
  - The valid bit is set on that `pmem_resp` edge unless `flush` is high in the same cycle or a flush occurred earlier in this FETCH. In either of those cases the fill is written but valid stays 0.
- Fills use the latched address, not the current `imem_address`. If the address changes mid-fetch, the fill completes anyway, then IDLE re-checks the new address.
- `flush`:
  - clears all valid bits at the next edge;
  - in IDLE it suppresses hit and miss-start for that cycle;
  - in FETCH it does not abort the bus transaction (`pmem_read` stays high until `pmem_resp`).
- `pmem_resp` outside FETCH is ignored.

## Timing
- Reset (async, `rst_n`=0):
  - state=IDLE; all valid=0; `pmem_read`=0; `pmem_address`=0;
  - `imem_resp`=0, since no line is valid;
  - effective immediately, including mid-FETCH: `pmem_read` drops without waiting for the clock.
- Hit latency: 0 cycles, with `imem_resp` in the same cycle the address is presented.
- Miss timeline:
  - cycle N: miss, `imem_resp`=0.
  - cycle N+1: `pmem_read`=1.
  - cycle K: `pmem_resp`=1 (K≥N+1).
  - cycle K+1: IDLE, `imem_resp`=1, `pmem_read`=0.
  - Total miss penalty = K-N+1 cycles.
- Back-to-back misses: no bubble beyond one IDLE cycle between fills; `pmem_read` is low for exactly that cycle.
- `pmem_read` never stays asserted in the cycle after `pmem_resp`.
- `imem_resp` is never high while state=FETCH, even if the current address hits another line.

## Test plan
- **Cold miss:**
  - Stimulus: release reset; present 0x00000040; respond to `pmem_read` after 3 cycles with line words 0x1000_0000..0x1000_0007.
  - Required: `pmem_address`=0x00000040, `pmem_read` high for exactly 4 cycles, then `imem_resp`=1 with `imem_rdata`=0x1000_0000.
- **Same-line hits:**
  - Stimulus: after the fill, present 0x44, 0x5C, 0x4E.
  - Required: `imem_resp`=1 every cycle; data 0x1000_0001, 0x1000_0007, 0x1000_0003; `pmem_read` stays 0.
- **Conflict miss:**
  - Stimulus: present 0x00000140 (same index 2, different tag).
  - Required: miss with `pmem_address`=0x140; after the fill, 0x40 misses again.
- **Flush:**
  - Stimulus: pulse `flush` in IDLE, then present 0x40.
  - Required: `imem_resp`=0 and a new fill is issued.
- **Flush during FETCH:**
  - Stimulus: pulse `flush` two cycles into a fill of 0x40.
  - Required: the fill completes and `pmem_read` drops after `pmem_resp`; in the next cycle 0x40 still misses and refetches.
- **Reset mid-fetch:**
  - Stimulus: assert `rst_n`=0 while `pmem_read`=1.
  - Required: `pmem_read`=0 and `imem_resp`=0 immediately (before the next edge); after release, every address misses.
